ifu_fetch: RTL and testbench

Instruction fetch unit, downstream of the PC register. It takes the sequential fetch address, issues in-order requests to instruction memory over a valid/ready channel, and buffers returned instructions with their PCs in a small FIFO. It presents instructions to decode through a valid/ready handshake. A branch/jump redirect flushes the buffer and discards responses for wrong-path requests still in flight.

---
 rtl/ifu_fetch.sv | 163 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit.
//
// Issues in-order word fetches starting at RESET_PC to instruction memory.
// Returned words are buffered with their PCs in a DEPTH-entry FIFO, which
// feeds decode. The FIFO entries plus the requests still in flight never
// exceed DEPTH, so a response always finds room in the FIFO.
//
// A redirect reloads the fetch PC and flushes the FIFO. It also arms a
// counter that discards the responses of wrong-path requests still in
// flight.
//
// Build option:
//   IFU_BYPASS_EN  When defined, a kept response that arrives while the FIFO
//                  is empty is presented to decode in the same cycle.
//                  When undefined, every instruction goes through the FIFO,
//                  and nothing on imem_rsp_* reaches id_* combinationally.
//
// Parameters:
//   DEPTH     FIFO entries and outstanding-request limit (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   redirect_valid, redirect_pc      restart fetch at redirect_pc & ~3
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order fetch responses
//   id_valid/ready, id_instr, id_pc  instruction channel to decode
module ifu_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]   credit_used;
  logic          fifo_empty;
  logic          req_fire;
  logic          rsp_keep;
  logic          byp_vld;
  logic          byp_take;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_base;

  assign redirect_base = redirect_pc & ~32'd3;
  assign credit_used   = {1'b0, count} + {1'b0, outstanding};
  assign fifo_empty    = (count == '0);

  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only if no wrong-path responses remain to be dropped
  // and no redirect is squashing it in this very cycle.
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

`ifdef IFU_BYPASS_EN
  assign byp_vld  = fifo_empty && rsp_keep;
  assign byp_take = byp_vld && id_ready;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed response consumed by decode never enters the FIFO.
  assign push = rsp_keep && !byp_take;
  assign pop  = !fifo_empty && !redirect_valid && id_ready;

  assign id_valid = rst_n && !redirect_valid && (!fifo_empty || byp_vld);

  always_comb begin
    id_instr = 32'h0;
    id_pc    = RESET_PC;
    if (rst_n) begin
      if (!fifo_empty) begin
        id_instr = instr_mem[rd_ptr];
        id_pc    = pc_mem[rd_ptr];
      end else if (byp_vld) begin
        id_instr = imem_rsp_data;
        id_pc    = rsp_pc;
      end else begin
        id_pc    = rsp_pc;
      end
    end
  end

  // Control state: PCs, FIFO pointers and the credit/drop counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // Everything still in flight after this cycle is wrong-path. The
        // request term is always zero because requests are blocked here.
        drop_cnt <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO payload storage; its contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  ifu_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory requests in flight tagged with the fetch epoch
  // they were issued in, and the queue of instructions awaiting decode.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        infl[$];
  ent_t        mq[$];
  logic [31:0] m_fetch;
  int          epoch;
  int          cyc;
  int          lat;
  int          checks;
  int          failures;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    id_ready       = 1'b1;
    infl.delete();
    mq.delete();
    m_fetch = RESET_PC;
    epoch   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_id_valid",  32'(id_valid),       32'h0);
    chk("rst_id_instr",  id_instr,            32'h0);
    chk("rst_id_pc",     id_pc,               RESET_PC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic redir, input logic [31:0] rpc,
                      input logic rq_rdy, input logic idr, input bit rsp_ok);
    bit          rsp;
    bit          keep;
    bit          byp;
    bit          exp_req;
    bit          exp_idv;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    req_t        r;

    rsp = rsp_ok && (infl.size() > 0);
    if (rsp) rsp = (infl[0].due <= cyc);

    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rq_rdy;
    id_ready       = idr;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? instr_of(infl[0].addr) : $urandom;

    keep = 1'b0;
    if (rsp) keep = (infl[0].epoch == epoch) && !redir;
    exp_req = !redir && ((mq.size() + infl.size()) < DEPTH);
    byp     = 1'b0;
    exp_idv = 1'b0;
    exp_pc  = 32'h0;
    exp_ins = 32'h0;
    if (mq.size() != 0 && !redir) begin
      exp_idv = 1'b1;
      exp_pc  = mq[0].pc;
      exp_ins = mq[0].instr;
    end
`ifdef IFU_BYPASS_EN
    else if (keep) begin
      byp     = 1'b1;
      exp_idv = 1'b1;
      exp_pc  = infl[0].addr;
      exp_ins = instr_of(infl[0].addr);
    end
`endif

    @(negedge clk);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, m_fetch);
    chk("id_valid", 32'(id_valid), 32'(exp_idv));
    if (exp_idv) begin
      chk("id_pc",    id_pc,    exp_pc);
      chk("id_instr", id_instr, exp_ins);
    end

    if (exp_idv && idr && !byp) void'(mq.pop_front());
    if (rsp) begin
      r = infl.pop_front();
      if (keep && !(byp && idr)) mq.push_back('{r.addr, instr_of(r.addr)});
    end
    if (redir) begin
      mq.delete();
      m_fetch = rpc & ~32'd3;
      epoch++;
    end else if (exp_req && rq_rdy) begin
      infl.push_back('{m_fetch, epoch, cyc + lat});
      m_fetch = m_fetch + 32'd4;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    lat      = 1;

    do_reset();

    // 1-cycle memory, decode always ready: streaming fetch.
    lat = 1;
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    drain();

    // Decode stalled: credits run out after DEPTH requests, then drain.
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    drain();

    // Memory not accepting: request address holds, nothing reaches decode.
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Redirect with two requests outstanding.
    lat = 3;
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    drain();

    // Redirect coinciding with a response and a would-be decode handshake.
    lat = 1;
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Fetch PC wrap past the top of the address space.
    step(1'b1, 32'hFFFF_FFFA, 1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Back-to-back redirects.
    lat = 2;
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h0000_2001, 1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of traffic.
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do_reset();
    lat = 1;
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        rd;
      logic [31:0] tgt;
      lat = $urandom_range(1, 3);
      rd  = ($urandom_range(0, 99) < 5);
      tgt = $urandom;
      step(rd, tgt,
           ($urandom_range(0, 99) < 75),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 90));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
